// File: rtl/bcd_time_base.sv
// BCD time-of-day base for the binary clock: synchronises the RTC 1 Hz wave,
// debounces the set button, and keeps HH:MM:SS (24 h) with a fast-set mode.
module bcd_time_base #(
    parameter int MAIN_CLK    = 12000000,
    parameter int FAST_HZ     = 1000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       CLK_1HZ,
    input  logic       BTN,
    output logic [3:0] ds0,
    output logic [3:0] ds1,
    output logic [3:0] dm0,
    output logic [3:0] dm1,
    output logic [3:0] dh0,
    output logic [3:0] dh1,
    output logic       tick,
    output logic       fast_mode,
    output logic       midday
);

    localparam int FAST_DIV        = MAIN_CLK / FAST_HZ;
    localparam int DEBOUNCE_CYCLES = (MAIN_CLK / 1000) * DEBOUNCE_MS;
    localparam int PW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(FAST_DIV - 1);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic          c_sync1_q, c_sync2_q, c_hist_q;
    logic          b_sync1_q, b_sync2_q;
    logic          btn_db_q;
    logic [DW-1:0] dcnt_q;
    logic          fast_mode_q;
    logic [PW-1:0] pcnt_q;
    logic          tick_q;
    logic [3:0]    ds0_q, ds1_q, dm0_q, dm1_q, dh0_q, dh1_q;
    logic [3:0]    ds0_d, ds1_d, dm0_d, dm1_d, dh0_d, dh1_d;
    logic          sec_pulse, fast_pulse, advance;

    assign sec_pulse  = c_sync2_q & ~c_hist_q;
    assign fast_pulse = fast_mode_q & (pcnt_q == P_MAX);
    assign advance    = fast_mode_q ? fast_pulse : sec_pulse;

    // Input synchronisers; idle-high so a level present at reset is not an edge
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            c_sync1_q <= 1'b1;
            c_sync2_q <= 1'b1;
            c_hist_q  <= 1'b1;
            b_sync1_q <= 1'b1;
            b_sync2_q <= 1'b1;
        end else begin
            c_sync1_q <= CLK_1HZ;
            c_sync2_q <= c_sync1_q;
            c_hist_q  <= c_sync2_q;
            b_sync1_q <= BTN;
            b_sync2_q <= b_sync1_q;
        end
    end

    // Button debounce: accept a new level only after it stays put long enough
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            btn_db_q <= 1'b1;
            dcnt_q   <= '0;
        end else if (b_sync2_q == btn_db_q) begin
            dcnt_q <= '0;
        end else if (dcnt_q == D_MAX) begin
            btn_db_q <= b_sync2_q;
            dcnt_q   <= '0;
        end else begin
            dcnt_q <= dcnt_q + 1'b1;
        end
    end

    // Fast-set prescaler; cleared on the very edge fast mode drops out
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fast_mode_q <= 1'b0;
            pcnt_q      <= '0;
        end else begin
            fast_mode_q <= ~btn_db_q;
            if (!fast_mode_q || btn_db_q) begin
                pcnt_q <= '0;
            end else if (pcnt_q == P_MAX) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + 1'b1;
            end
        end
    end

    // Cascaded BCD increment of HH:MM:SS with 23:59:59 wrapping to 00:00:00
    always_comb begin
        ds0_d = ds0_q;
        ds1_d = ds1_q;
        dm0_d = dm0_q;
        dm1_d = dm1_q;
        dh0_d = dh0_q;
        dh1_d = dh1_q;
        if (advance) begin
            if (ds0_q != 4'd9) begin
                ds0_d = ds0_q + 4'd1;
            end else begin
                ds0_d = 4'd0;
                if (ds1_q != 4'd5) begin
                    ds1_d = ds1_q + 4'd1;
                end else begin
                    ds1_d = 4'd0;
                    if (dm0_q != 4'd9) begin
                        dm0_d = dm0_q + 4'd1;
                    end else begin
                        dm0_d = 4'd0;
                        if (dm1_q != 4'd5) begin
                            dm1_d = dm1_q + 4'd1;
                        end else begin
                            dm1_d = 4'd0;
                            if (dh1_q == 4'd2 && dh0_q == 4'd3) begin
                                dh1_d = 4'd0;
                                dh0_d = 4'd0;
                            end else if (dh0_q == 4'd9) begin
                                dh0_d = 4'd0;
                                dh1_d = dh1_q + 4'd1;
                            end else begin
                                dh0_d = dh0_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Digit registers and the update strobe share one edge
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ds0_q  <= 4'd0;
            ds1_q  <= 4'd0;
            dm0_q  <= 4'd0;
            dm1_q  <= 4'd0;
            dh0_q  <= 4'd0;
            dh1_q  <= 4'd0;
            tick_q <= 1'b0;
        end else begin
            ds0_q  <= ds0_d;
            ds1_q  <= ds1_d;
            dm0_q  <= dm0_d;
            dm1_q  <= dm1_d;
            dh0_q  <= dh0_d;
            dh1_q  <= dh1_d;
            tick_q <= advance;
        end
    end

    assign ds0       = ds0_q;
    assign ds1       = ds1_q;
    assign dm0       = dm0_q;
    assign dm1       = dm1_q;
    assign dh0       = dh0_q;
    assign dh1       = dh1_q;
    assign tick      = tick_q;
    assign fast_mode = fast_mode_q;
    assign midday    = ({dh1_q, dh0_q, dm1_q, dm0_q} == 16'h0000) ||
                       ({dh1_q, dh0_q, dm1_q, dm0_q} == 16'h1200);

endmodule

// File: tb/tb_bcd_time_base.sv
// Bench for bcd_time_base: boundary table, timed CLK_1HZ edges, random runs
// against a seconds-of-day model, debounce / fast-set and async reset cases.
module tb_bcd_time_base;

    logic CLK = 1'b0;
    logic reset, CLK_1HZ, BTN;
    logic [3:0] ds0, ds1, dm0, dm1, dh0, dh1;
    logic tick, fast_mode, midday;
    logic [23:0] digits;
    logic [23:0] pre_bcd;

    int nvec = 0;
    int nmis = 0;
    int t_ref = 0;
    int tick_seen = 0;

    typedef struct {
        int          start;
        int          nadv;
        logic [23:0] exp_bcd;
        logic        exp_mid;
    } vec_t;

    vec_t tbl[9];

    bcd_time_base #(
        .MAIN_CLK(1000),
        .FAST_HZ(100),
        .DEBOUNCE_MS(4)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .CLK_1HZ(CLK_1HZ),
        .BTN(BTN),
        .ds0(ds0),
        .ds1(ds1),
        .dm0(dm0),
        .dm1(dm1),
        .dh0(dh0),
        .dh1(dh1),
        .tick(tick),
        .fast_mode(fast_mode),
        .midday(midday)
    );

    always #5 CLK = ~CLK;

    assign digits = {dh1, dh0, dm1, dm0, ds1, ds0};

    always @(negedge CLK) if (tick === 1'b1) tick_seen++;

    function automatic logic [23:0] to_bcd(int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic ref_midday(int t);
        int hm;
        hm = t / 60;
        return (hm == 0) || (hm == 720);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_model(string nm);
        chk({nm, " digits"}, 32'(digits), 32'(to_bcd(t_ref)));
        chk({nm, " midday"}, 32'(midday), 32'(ref_midday(t_ref)));
    endtask

    task automatic preload(int t);
        @(negedge CLK);
        pre_bcd = to_bcd(t);
        force dut.ds0_q = pre_bcd[3:0];
        force dut.ds1_q = pre_bcd[7:4];
        force dut.dm0_q = pre_bcd[11:8];
        force dut.dm1_q = pre_bcd[15:12];
        force dut.dh0_q = pre_bcd[19:16];
        force dut.dh1_q = pre_bcd[23:20];
        #1;
        release dut.ds0_q;
        release dut.ds1_q;
        release dut.dm0_q;
        release dut.dm1_q;
        release dut.dh0_q;
        release dut.dh1_q;
        t_ref = t;
    endtask

    task automatic rise(int hi, int lo);
        @(negedge CLK);
        CLK_1HZ = 1'b1;
        repeat (hi) @(negedge CLK);
        CLK_1HZ = 1'b0;
        repeat (lo) @(negedge CLK);
        t_ref = (t_ref + 1) % 86400;
    endtask

    task automatic rise_timed();
        @(negedge CLK);
        CLK_1HZ = 1'b1;
        @(negedge CLK);
        chk("tick edge1", 32'(tick), 32'd0);
        @(negedge CLK);
        chk("tick edge2", 32'(tick), 32'd0);
        CLK_1HZ = 1'b0;
        @(negedge CLK);
        chk("tick edge3", 32'(tick), 32'd1);
        t_ref = (t_ref + 1) % 86400;
        check_model("timed rise");
        @(negedge CLK);
        chk("tick edge4", 32'(tick), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        bit exp_tick;
        int ticks0;

        tbl[0] = '{86399, 1,  24'h000000, 1'b1};
        tbl[1] = '{35999, 1,  24'h100000, 1'b0};
        tbl[2] = '{71999, 1,  24'h200000, 1'b0};
        tbl[3] = '{43199, 1,  24'h120000, 1'b1};
        tbl[4] = '{43200, 60, 24'h120100, 1'b0};
        tbl[5] = '{59,    1,  24'h000100, 1'b0};
        tbl[6] = '{3599,  1,  24'h010000, 1'b0};
        tbl[7] = '{45296, 1,  24'h123457, 1'b0};
        tbl[8] = '{0,     3,  24'h000003, 1'b1};

        reset   = 1'b1;
        CLK_1HZ = 1'b1;
        BTN     = 1'b1;
        #12;
        chk("reset digits", 32'(digits), 32'd0);
        chk("reset tick", 32'(tick), 32'd0);
        chk("reset fast_mode", 32'(fast_mode), 32'd0);
        chk("reset midday", 32'(midday), 32'd1);

        @(negedge CLK);
        reset = 1'b0;
        repeat (8) @(negedge CLK);
        chk("high at release digits", 32'(digits), 32'd0);
        chk("high at release ticks", 32'(tick_seen), 32'd0);
        CLK_1HZ = 1'b0;
        repeat (3) @(negedge CLK);

        repeat (12) rise_timed();
        chk("12 rises ds1:ds0", 32'({ds1, ds0}), 32'h12);
        chk("12 rises tick count", 32'(tick_seen), 32'd12);

        for (int i = 0; i < 9; i++) begin
            preload(tbl[i].start);
            repeat (tbl[i].nadv) rise(2, 2);
            chk($sformatf("table %0d digits", i), 32'(digits),
                32'(tbl[i].exp_bcd));
            chk($sformatf("table %0d midday", i), 32'(midday),
                32'(tbl[i].exp_mid));
            check_model($sformatf("table %0d model", i));
        end

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) preload($urandom_range(0, 86399));
            rise($urandom_range(2, 5), $urandom_range(2, 5));
            check_model($sformatf("random %0d", i));
        end

        preload(3595);
        for (int b = 0; b < 4; b++) begin
            BTN = (b % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) begin
                @(negedge CLK);
                chk("bounce fast_mode", 32'(fast_mode), 32'd0);
            end
        end
        BTN = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(negedge CLK);
            chk($sformatf("debounce edge %0d", e), 32'(fast_mode),
                32'(e == 7));
        end
        for (int k = 1; k <= 60; k++) begin
            if (k <= 30) CLK_1HZ = ((k / 2) % 2 == 1);
            @(negedge CLK);
            exp_tick = (k < 37) && (k % 10 == 0);
            chk($sformatf("fast tick k=%0d", k), 32'(tick), 32'(exp_tick));
            if (exp_tick) t_ref = (t_ref + 1) % 86400;
            chk($sformatf("fast level k=%0d", k), 32'(fast_mode),
                32'(k < 37));
            if (k == 30) begin
                BTN     = 1'b1;
                CLK_1HZ = 1'b0;
            end
        end
        check_model("after fast");
        ticks0 = tick_seen;
        rise_timed();
        chk("post-fast single advance", 32'(tick_seen - ticks0), 32'd1);

        preload(15 * 3600 + 42 * 60 + 7);
        BTN = 1'b0;
        repeat (9) @(negedge CLK);
        chk("pre-reset fast_mode", 32'(fast_mode), 32'd1);
        check_model("pre-reset 15:42:07");
        #2;
        reset = 1'b1;
        #1;
        chk("async reset digits", 32'(digits), 32'd0);
        chk("async reset fast_mode", 32'(fast_mode), 32'd0);
        chk("async reset tick", 32'(tick), 32'd0);
        chk("async reset midday", 32'(midday), 32'd1);
        BTN = 1'b1;
        t_ref = 0;
        @(negedge CLK);
        reset = 1'b0;
        repeat (4) @(negedge CLK);
        check_model("after reset");
        chk("after reset fast_mode", 32'(fast_mode), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
